hazard_control_unit: RTL
========================

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter INT_DRAIN_CYCLES, default 2, number of cycles the pipeline drains before interrupt entry.
REQ-002 Parameter STALL_CNT_W, default 16, width of the stall performance counter.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-low reset sampled on posedge clk.
REQ-005 fd_src_1_num  input  3  source-1 register number of the instruction in the FD register.
REQ-006 fd_src_1_used  input  1  instruction in FD reads source 1.
REQ-007 fd_src_2_num  input  4  source-2 register number of the instruction in FD.
REQ-008 fd_src_2_used  input  1  instruction in FD reads source 2.
REQ-009 de_mem_read  input  1  instruction in DE is a load.
REQ-010 de_reg_write  input  1  instruction in DE writes a register.
REQ-011 de_dst_num  input  4  destination register number from DE register.
REQ-012 em_two_cycle  input  1  instruction in EM is a 32-bit memory access needing two cycles.
REQ-013 int_req  input  1  level interrupt request.
REQ-014 pc_hold, fd_hold, de_hold, em_hold  output  1 each  freeze PC / FD / DE / EM register.
REQ-015 fd_flush, de_flush  output  1 each  load zero (bubble) into FD / DE on next edge.
REQ-016 mem_phase  output  1  EM instruction is in its second memory cycle.
REQ-017 int_ack  output  1  one-cycle pulse; PC loads the interrupt vector on that edge.
REQ-018 stall_count  output  STALL_CNT_W  saturating count of load-use bubbles inserted.

Function
REQ-019 FSM states RUN, MEM2, INT_DRAIN, INT_ENTER; reset state RUN.
REQ-020 Load-use hazard lu = de_mem_read & de_reg_write & ((fd_src_1_used & de_dst_num == {1'b0,fd_src_1_num}) | (fd_src_2_used & de_dst_num == fd_src_2_num)).
REQ-021 RUN & em_two_cycle: pc_hold=fd_hold=de_hold=em_hold=1, all flushes 0 this cycle; next state MEM2.
REQ-022 MEM2: all holds 0, mem_phase=1, em_two_cycle ignored; next state RUN (second cycle never re-triggers MEM2).
REQ-023 RUN & !em_two_cycle & lu: pc_hold=fd_hold=1, de_flush=1, same cycle (combinational); stays RUN; stall_count increments by 1, saturating at all-ones.
REQ-024 Hold takes priority over flush: de_flush=0 whenever de_hold=1.
REQ-025 int_pending register sets when int_req=1 in any state, clears on int_ack cycle.
REQ-026 RUN & int_pending & !em_two_cycle & !lu: next state INT_DRAIN, counter loaded with INT_DRAIN_CYCLES-1.
REQ-027 INT_DRAIN: pc_hold=1, fd_flush=1; counter decrements each cycle; at 0 next state INT_ENTER; em_two_cycle during drain holds all stages for one cycle and takes the MEM2 path, with the counter frozen and return to INT_DRAIN.
REQ-028 INT_ENTER: int_ack=1, fd_flush=1, pc_hold=0; next state RUN.
REQ-029 Priority in RUN: em_two_cycle > lu > int_pending.
REQ-030 int_req asserted while int_pending=1 is absorbed (no second entry until after int_ack).

Reset
REQ-031 reset=0 at a posedge: state=RUN, int_pending=0, drain counter=0, stall_count=0; all outputs 0 in the following cycle.
REQ-032 reset mid-MEM2 or mid-INT_DRAIN abandons the sequence; no int_ack issued for a pending request.

Structure
REQ-033 Shared package/header: FSM state encoding, register-number widths (3 and 4), INT_DRAIN_CYCLES default.
REQ-034 One sub-module load_use_detector (combinational lu compare); FSM, counters and output decode in the top.

Verification
REQ-035 de_mem_read=1, de_reg_write=1, de_dst_num=4'd3, fd_src_1_num=3'd3, used=1 -> same cycle pc_hold=fd_hold=de_flush=1, stall_count 0->1.
REQ-036 Same as REQ-035 with de_dst_num=4'd11, fd_src_1_num=3'd3 -> no stall (bit-3 mismatch).
REQ-037 em_two_cycle held high 2 cycles -> cycle 1 all holds=1, cycle 2 mem_phase=1 and holds=0, cycle 3 RUN.
REQ-038 int_req 1-cycle pulse in RUN, default parameter -> 2 cycles fd_flush+pc_hold, then int_ack=1 for exactly 1 cycle.
REQ-039 int_req and lu in the same cycle -> bubble first, INT_DRAIN entered next cycle.
REQ-040 reset=0 during INT_DRAIN -> int_ack never asserts; 2^16 lu cycles -> stall_count saturates at 16'hFFFF.

Source files
------------

// File: rtl/hazard_control_unit_pkg.sv
// hazard_control_unit_pkg: shared FSM encoding, register-number widths and defaults
// Ports: none (package).
package hazard_control_unit_pkg;
    localparam int SRC1_W               = 3;
    localparam int REG_W                = 4;
    localparam int DEF_INT_DRAIN_CYCLES = 2;
    localparam int DEF_STALL_CNT_W      = 16;
    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM2,
        ST_INT_DRAIN,
        ST_INT_ENTER
    } state_e;
endpackage

// File: rtl/load_use_detector.sv
// load_use_detector: flags a load in DE whose destination feeds the instruction in FD
// Ports:
//   fd_src_1_num/used, fd_src_2_num/used - FD source operands
//   de_mem_read, de_reg_write, de_dst_num - DE load destination
//   lu                                   - load-use hazard (combinational)
module load_use_detector
    import hazard_control_unit_pkg::*;
(
    input  logic [SRC1_W-1:0] fd_src_1_num,
    input  logic              fd_src_1_used,
    input  logic [REG_W-1:0]  fd_src_2_num,
    input  logic              fd_src_2_used,
    input  logic              de_mem_read,
    input  logic              de_reg_write,
    input  logic [REG_W-1:0]  de_dst_num,
    output logic              lu
);
    // Source 1 only reaches the low registers, so its upper bit is always zero.
    assign lu = de_mem_read & de_reg_write &
                ((fd_src_1_used & (de_dst_num == {1'b0, fd_src_1_num})) |
                 (fd_src_2_used & (de_dst_num == fd_src_2_num)));
endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: pipeline hold/flush control for load-use, two-cycle memory and interrupts
// Ports:
//   clk, reset (sync, active-low)
//   fd_src_*, de_*            - hazard detection operands
//   em_two_cycle              - EM needs a second memory cycle
//   int_req                   - level interrupt request
//   *_hold, *_flush           - pipeline register control
//   mem_phase, int_ack        - second memory cycle / interrupt vector load
//   stall_count               - saturating count of load-use bubbles
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int INT_DRAIN_CYCLES = DEF_INT_DRAIN_CYCLES,
    parameter int STALL_CNT_W      = DEF_STALL_CNT_W
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [SRC1_W-1:0]      fd_src_1_num,
    input  logic                   fd_src_1_used,
    input  logic [REG_W-1:0]       fd_src_2_num,
    input  logic                   fd_src_2_used,
    input  logic                   de_mem_read,
    input  logic                   de_reg_write,
    input  logic [REG_W-1:0]       de_dst_num,
    input  logic                   em_two_cycle,
    input  logic                   int_req,
    output logic                   pc_hold,
    output logic                   fd_hold,
    output logic                   de_hold,
    output logic                   em_hold,
    output logic                   fd_flush,
    output logic                   de_flush,
    output logic                   mem_phase,
    output logic                   int_ack,
    output logic [STALL_CNT_W-1:0] stall_count
);
    localparam int CNT_W = (INT_DRAIN_CYCLES > 1) ? $clog2(INT_DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(INT_DRAIN_CYCLES - 1);

    state_e                 state_q, state_d;
    logic                   pend_q, pend_d;
    logic                   ret_q, ret_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic                   lu, bubble, fd_f, de_f;

    load_use_detector u_lud (
        .fd_src_1_num  (fd_src_1_num),
        .fd_src_1_used (fd_src_1_used),
        .fd_src_2_num  (fd_src_2_num),
        .fd_src_2_used (fd_src_2_used),
        .de_mem_read   (de_mem_read),
        .de_reg_write  (de_reg_write),
        .de_dst_num    (de_dst_num),
        .lu            (lu)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ret_d     = ret_q;
        pc_hold   = 1'b0;
        fd_hold   = 1'b0;
        de_hold   = 1'b0;
        em_hold   = 1'b0;
        fd_f      = 1'b0;
        de_f      = 1'b0;
        mem_phase = 1'b0;
        int_ack   = 1'b0;
        bubble    = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (em_two_cycle) begin
                    {pc_hold, fd_hold, de_hold, em_hold} = 4'hF;
                    state_d = ST_MEM2;
                    ret_d   = 1'b0;
                end else if (lu) begin
                    pc_hold = 1'b1;
                    fd_hold = 1'b1;
                    de_f    = 1'b1;
                    bubble  = 1'b1;
                end else if (pend_q) begin
                    state_d = ST_INT_DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end
            end
            // ret_q remembers whether the memory stall interrupted a drain.
            ST_MEM2: begin
                mem_phase = 1'b1;
                state_d   = ret_q ? ST_INT_DRAIN : ST_RUN;
            end
            // A two-cycle access during drain freezes the drain count until it completes.
            ST_INT_DRAIN: begin
                if (em_two_cycle) begin
                    {pc_hold, fd_hold, de_hold, em_hold} = 4'hF;
                    state_d = ST_MEM2;
                    ret_d   = 1'b1;
                end else begin
                    pc_hold = 1'b1;
                    fd_f    = 1'b1;
                    state_d = (cnt_q == '0) ? ST_INT_ENTER : ST_INT_DRAIN;
                    cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
                end
            end
            ST_INT_ENTER: begin
                int_ack = 1'b1;
                fd_f    = 1'b1;
                state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
        // Requests arriving while one is pending are absorbed; the ack clears it.
        pend_d  = ~int_ack & (pend_q | int_req);
        stall_d = (bubble && stall_q != '1) ? stall_q + 1'b1 : stall_q;
    end

    // A held register must keep its contents, so hold masks flush.
    assign fd_flush    = fd_f & ~fd_hold;
    assign de_flush    = de_f & ~de_hold;
    assign stall_count = stall_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_RUN;
            pend_q  <= 1'b0;
            ret_q   <= 1'b0;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end
endmodule
